// File: rtl/btree_node_writer.sv
// B-tree node register file with a sorted insert/update engine and registered read port.
// Optional: define BTREE_NODE_WRITER_DELETE_EN to make op=1 delete a key.
module btree_node_writer #(
  parameter int KEY_BITS  = 8,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8,
  parameter int BLOCKS    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op,
  input  logic [ADDR_BITS-1:0]   address,
  input  logic [KEY_BITS-1:0]    key,
  input  logic [DATA_BITS-1:0]   data,
  input  logic [ADDR_BITS-1:0]   next,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             status,
  input  logic [ADDR_BITS-1:0]   rd_address,
  output logic [1:0]             rd_count,
  output logic [3*KEY_BITS-1:0]  rd_keys,
  output logic [3*DATA_BITS-1:0] rd_data,
  output logic [4*ADDR_BITS-1:0] rd_next
);
  localparam int IDX_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

  localparam logic [1:0] ST_DONE     = 2'd0;
  localparam logic [1:0] ST_UPDATED  = 2'd1;
  localparam logic [1:0] ST_REJECTED = 2'd2;
  localparam logic [1:0] ST_BAD_ADDR = 2'd3;

  // Index 0 sits in the LSBs so the packed fields map straight onto rd_*.
  typedef struct packed {
    logic [3:0][ADDR_BITS-1:0] nxt;
    logic [2:0][DATA_BITS-1:0] data;
    logic [2:0][KEY_BITS-1:0]  keys;
    logic [1:0]                count;
  } node_t;

  typedef struct packed {
    logic                 op;
    logic [ADDR_BITS-1:0] addr;
    logic [KEY_BITS-1:0]  key;
    logic [DATA_BITS-1:0] data;
    logic [ADDR_BITS-1:0] nxt;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLACE, S_DONE} state_t;

  state_t     state_q, state_d;
  req_t       req_q;
  node_t      work_q;
  node_t      rd_q;
  node_t      mem [BLOCKS];
  logic [1:0] status_q;

  logic             addr_ok, rd_ok;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  node_t      place_node;
  logic       place_wr;
  logic [1:0] place_status;
  int         cnt, ins_p, hit_i;
  logic       hit;

  assign addr_ok = 32'(req_q.addr) < BLOCKS;
  assign rd_ok   = 32'(rd_address) < BLOCKS;
  assign wr_idx  = req_q.addr[IDX_W-1:0];
  assign rd_idx  = rd_address[IDX_W-1:0];

`ifndef BTREE_NODE_WRITER_DELETE_EN
  logic unused_op;
  assign unused_op = req_q.op;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = addr_ok ? S_PLACE : S_DONE;
      S_PLACE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Only slots below count take part in the compare; stale upper slots are ignored.
  always_comb begin
    place_node   = work_q;
    place_wr     = 1'b0;
    place_status = ST_REJECTED;
    cnt          = int'(work_q.count);
    ins_p        = 0;
    hit          = 1'b0;
    hit_i        = 0;
    for (int i = 0; i < 3; i++) begin
      if (i < cnt) begin
        if (req_q.key == work_q.keys[i]) begin
          hit   = 1'b1;
          hit_i = i;
        end
        if (req_q.key > work_q.keys[i]) ins_p++;
      end
    end
`ifdef BTREE_NODE_WRITER_DELETE_EN
    if (req_q.op) begin
      if (hit) begin
        for (int j = 0; j < 2; j++) begin
          if (j >= hit_i && j < cnt - 1) begin
            place_node.keys[j] = work_q.keys[j+1];
            place_node.data[j] = work_q.data[j+1];
          end
        end
        for (int j = 0; j < 3; j++) begin
          if (j == cnt - 1) begin
            place_node.keys[j] = '0;
            place_node.data[j] = '0;
          end
        end
        // Removing key i drops its right child next[i+1].
        for (int k = 1; k < 3; k++)
          if (k > hit_i && k < cnt) place_node.nxt[k] = work_q.nxt[k+1];
        for (int k = 1; k < 4; k++)
          if (k == cnt) place_node.nxt[k] = '0;
        place_node.count = work_q.count - 2'd1;
        place_status     = ST_DONE;
        place_wr         = 1'b1;
      end
    end else begin
`else
    begin
`endif
      if (hit) begin
        for (int i = 0; i < 3; i++)
          if (i == hit_i) place_node.data[i] = req_q.data;
        place_status = ST_UPDATED;
        place_wr     = 1'b1;
      end else if (cnt < 3) begin
        for (int j = 0; j < 3; j++) begin
          if (j == ins_p) begin
            place_node.keys[j] = req_q.key;
            place_node.data[j] = req_q.data;
          end
        end
        for (int j = 1; j < 3; j++) begin
          if (j > ins_p && j <= cnt) begin
            place_node.keys[j] = work_q.keys[j-1];
            place_node.data[j] = work_q.data[j-1];
          end
        end
        for (int k = 1; k < 4; k++) begin
          if (k == ins_p + 1)
            place_node.nxt[k] = req_q.nxt;
          else if (k > ins_p + 1 && k <= cnt + 1)
            place_node.nxt[k] = work_q.nxt[k-1];
        end
        place_node.count = work_q.count + 2'd1;
        place_status     = ST_DONE;
        place_wr         = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q    <= '0;
      work_q   <= '0;
      rd_q     <= '0;
      status_q <= ST_DONE;
      for (int b = 0; b < BLOCKS; b++) mem[b] <= '0;
    end else begin
      case (state_q)
        S_IDLE:  if (start) req_q <= {op, address, key, data, next};
        S_LOAD: begin
          if (!addr_ok) status_q <= ST_BAD_ADDR;
          else          work_q   <= mem[wr_idx];
        end
        S_PLACE: begin
          status_q <= place_status;
          if (place_wr) mem[wr_idx] <= place_node;
        end
        default: ;
      endcase
      // Sampled before this edge's write lands, so a same-node read sees old contents.
      rd_q <= rd_ok ? mem[rd_idx] : '0;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign status   = status_q;
  assign rd_count = rd_q.count;
  assign rd_keys  = rd_q.keys;
  assign rd_data  = rd_q.data;
  assign rd_next  = rd_q.nxt;
endmodule

// File: tb/tb_btree_node_writer.sv
// Bench for btree_node_writer: queue-based node model plus directed requests.
module tb_btree_node_writer;
  logic        clock, reset, start, op;
  logic [7:0]  address, key, data, nxt_in, rd_address;
  logic        busy, done;
  logic [1:0]  status, rd_count;
  logic [23:0] rd_keys, rd_data;
  logic [31:0] rd_next;

  btree_node_writer dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .address(address),
    .key(key), .data(data), .next(nxt_in), .busy(busy), .done(done),
    .status(status), .rd_address(rd_address), .rd_count(rd_count),
    .rd_keys(rd_keys), .rd_data(rd_data), .rd_next(rd_next)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  logic [7:0] mk [16][3];
  logic [7:0] md [16][3];
  logic [7:0] mn [16][4];
  int         mc [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void m_clear();
    for (int a = 0; a < 16; a++) begin
      mc[a] = 0;
      for (int i = 0; i < 3; i++) begin mk[a][i] = 0; md[a][i] = 0; end
      for (int i = 0; i < 4; i++) mn[a][i] = 0;
    end
  endfunction

  // Node as a sorted list of (key, data, right child); next0 is never touched.
  function automatic logic [1:0] m_apply(input bit o, input int a,
                                         input logic [7:0] k, d, n);
    logic [7:0] kq[$], dq[$], rq[$];
    int pos, ins;
    bit do_del;
    logic [1:0] st;
    do_del = 0;
`ifdef BTREE_NODE_WRITER_DELETE_EN
    do_del = o;
`endif
    if (a >= 16) return 2'd3;
    for (int i = 0; i < mc[a]; i++) begin
      kq.push_back(mk[a][i]); dq.push_back(md[a][i]); rq.push_back(mn[a][i+1]);
    end
    pos = -1;
    for (int i = 0; i < kq.size(); i++) if (kq[i] == k) pos = i;
    if (do_del) begin
      if (pos < 0) return 2'd2;
      kq.delete(pos); dq.delete(pos); rq.delete(pos);
      st = 2'd0;
    end else if (pos >= 0) begin
      dq[pos] = d;
      st = 2'd1;
    end else if (kq.size() == 3) begin
      return 2'd2;
    end else begin
      ins = 0;
      while (ins < kq.size() && kq[ins] < k) ins++;
      kq.insert(ins, k); dq.insert(ins, d); rq.insert(ins, n);
      st = 2'd0;
    end
    for (int i = 0; i < 3; i++) begin
      mk[a][i]   = (i < kq.size()) ? kq[i] : 8'h0;
      md[a][i]   = (i < kq.size()) ? dq[i] : 8'h0;
      mn[a][i+1] = (i < kq.size()) ? rq[i] : 8'h0;
    end
    mc[a] = kq.size();
    return st;
  endfunction

  logic [1:0]  e_cnt;
  logic [23:0] e_keys, e_data;
  logic [31:0] e_next;

  always @(posedge clock) begin
    int ra;
    ra = int'(rd_address);
    if (reset || ra >= 16) begin
      e_cnt = 0; e_keys = 0; e_data = 0; e_next = 0;
    end else begin
      e_cnt  = 2'(mc[ra]);
      e_keys = {mk[ra][2], mk[ra][1], mk[ra][0]};
      e_data = {md[ra][2], md[ra][1], md[ra][0]};
      e_next = {mn[ra][3], mn[ra][2], mn[ra][1], mn[ra][0]};
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("rd_count", rd_count, e_cnt);
      chk("rd_keys",  rd_keys,  e_keys);
      chk("rd_data",  rd_data,  e_data);
      chk("rd_next",  rd_next,  e_next);
    end
  end

  // Called and returns at a negedge; leaves the DUT idle one cycle after done.
  task automatic req(input bit o, input logic [7:0] a, k, d, n, output logic [1:0] st);
    int cyc, lat;
    logic [1:0] mst;
    lat = (a >= 16) ? 2 : 3;
    start = 1; op = o; address = a; key = k; data = d; nxt_in = n;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      start = 0;
      if (!done) chk("busy_wait", busy, 1);
    end while (!done && cyc < 8);
    st = status;
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done after %0d cycles want %0d", cyc, lat);
    end else begin
      chk("latency", cyc, lat);
      mst = m_apply(o, int'(a), k, d, n);
      chk("status", status, mst);
    end
    @(negedge clock);
    chk("idle_after", {busy, done}, 2'b00);
  endtask

  initial begin
    logic [1:0] st;
    reset = 1; start = 0; op = 0; address = 0; key = 0; data = 0; nxt_in = 0;
    rd_address = 3;
    m_clear();
    repeat (3) @(negedge clock);
    chk("rst_flags", {busy, done, status}, 4'b0);
    chk("rst_rd", {rd_count, rd_keys, rd_data, rd_next}, 0);
    reset = 0;
    chk_en = 1;

    req(0, 3, 8'h20, 8'h01, 8'h00, st);
    chk("first_st", st, 0);
    chk("first_cnt", rd_count, 1);
    chk("first_key", rd_keys, 24'h000020);
    chk("first_data", rd_data, 24'h000001);

    req(0, 3, 8'h40, 8'h02, 8'h00, st);
    req(0, 3, 8'h10, 8'h03, 8'h00, st);
    chk("sort_keys", rd_keys, 24'h402010);
    chk("sort_data", rd_data, 24'h020103);
    chk("sort_cnt", rd_count, 3);

    req(0, 3, 8'h30, 8'h04, 8'h00, st);
    chk("full_st", st, 2);
    chk("full_keys", rd_keys, 24'h402010);

    req(0, 3, 8'h20, 8'h77, 8'h00, st);
    chk("upd_st", st, 1);
    chk("upd_data", rd_data, 24'h027703);
    chk("upd_cnt", rd_count, 3);

    req(0, 20, 8'h05, 8'h05, 8'h00, st);
    chk("bad20_st", st, 3);
    req(0, 16, 8'h05, 8'h05, 8'h00, st);
    chk("bad16_st", st, 3);

    rd_address = 1;
    req(0, 1, 8'h50, 8'h0a, 8'h06, st);
    req(0, 1, 8'h30, 8'h0b, 8'h09, st);
    chk("child_next", rd_next, 32'h00060900);
    chk("child_keys", rd_keys, 24'h005030);
    req(0, 1, 8'h60, 8'h0c, 8'hff, st);
    chk("child_top", rd_next, 32'hff060900);

    req(0, 15, 8'haa, 8'h01, 8'h02, st);
    rd_address = 15;
    repeat (2) @(negedge clock);
    chk("n15_cnt", rd_count, 1);
    rd_address = 16;
    repeat (2) @(negedge clock);
    chk("rd16_zero", {rd_count, rd_keys}, 0);

    // Reset lands on the PLACE edge: no write, no done.
    rd_address = 5;
    start = 1; op = 0; address = 5; key = 8'h11; data = 8'h22; nxt_in = 0;
    @(negedge clock); start = 0;
    @(negedge clock);
    reset = 1; m_clear();
    @(negedge clock);
    chk("rstp_flags", {busy, done}, 2'b00);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rstp_nodone", {busy, done}, 2'b00);
    end
    chk("rstp_n5", rd_count, 0);
    rd_address = 3;
    repeat (2) @(negedge clock);
    chk("rstp_n3", rd_count, 0);

    rd_address = 2;
    req(0, 2, 8'h10, 8'h01, 8'h01, st);
    req(0, 2, 8'h20, 8'h02, 8'h02, st);
    req(0, 2, 8'h40, 8'h03, 8'h03, st);
    req(1, 2, 8'h20, 8'h00, 8'h00, st);
`ifdef BTREE_NODE_WRITER_DELETE_EN
    chk("del_st", st, 0);
    chk("del_keys", rd_keys, 24'h004010);
    chk("del_cnt", rd_count, 2);
    chk("del_next", rd_next, 32'h00030100);
    req(1, 2, 8'h99, 8'h00, 8'h00, st);
    chk("del_absent", st, 2);
    req(1, 2, 8'h10, 8'h00, 8'h00, st);
    chk("del_first", rd_keys, 24'h000040);
    chk("del_first_next", rd_next, 32'h00000300);
`else
    chk("op_ignored_st", st, 1);
    chk("op_ignored_data", rd_data, 24'h030001);
`endif
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/btree_node_writer.md
Name: btree_node_writer

Overview:
- Write-side companion to the combinational B-tree node search.
- Owns a small register-file of tree nodes. Each node holds a count, up to 3 sorted keys, 3 data words and 4 next pointers.
- Inserts or updates one key/data/right-child entry per request, keeping keys in ascending order, via a start/done handshake.
- Provides a registered node read-out port, which feeds the search logic and the test bench.

Parameters:
KEY_BITS, 8, key width; keys compared as unsigned over the full width
DATA_BITS, 8, data word width
ADDR_BITS, 8, node address / next-pointer width
BLOCKS, 16, number of nodes stored; valid addresses are 0..BLOCKS-1

Ports:
clock  input  1  single clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request strobe; accepted only when busy=0
op  input  1  0=insert/update, 1=delete (delete only with optional feature)
address  input  ADDR_BITS  target node
key  input  KEY_BITS  key to insert or delete
data  input  DATA_BITS  data for key
next  input  ADDR_BITS  right-child pointer stored after key; 0 for leaves
busy  output  1  high from the acceptance edge until done
done  output  1  one-cycle completion pulse
status  output  2  valid while done=1: 0 DONE, 1 UPDATED, 2 REJECTED, 3 BAD_ADDR
rd_address  input  ADDR_BITS  node to read out
rd_count  output  2  key count of node (0..3)
rd_keys  output  3*KEY_BITS  key1 in LSBs
rd_data  output  3*DATA_BITS  data1 in LSBs
rd_next  output  4*ADDR_BITS  next0 in LSBs

Behaviour:
- Reset (synchronous, highest priority):
  - every node is cleared: count=0, keys/data/next=0;
  - state=IDLE; busy=0, done=0, status=0;
  - rd_* outputs=0.
  - Reset during any state aborts the request; no node write occurs.
- FSM states: IDLE -> LOAD -> PLACE -> DONE -> IDLE.
  - IDLE: start=1 at edge N latches op/address/key/data/next, sets busy=1, goes to LOAD. In other states start is ignored (no queuing).
  - LOAD (edge N+1): copies node[address] into working registers.
    - If address >= BLOCKS: status=3, go to DONE, skip PLACE.
  - PLACE (edge N+2): computes eq[i] = (i < count) & key==key_i and gt[i] = (i < count) & key > key_i.
    - Insert position p = number of gt bits set.
    - Any eq: replace data of the matching slot, leave key/next unchanged, status=1.
    - Else if count==3: no write, status=2.
    - Else: keys/data at slots p..count-1 shift up one slot; next pointers p+1..count shift up one slot. key, data go to slot p and next to next[p+1]; count+1; status=0.
    - Node write and move to DONE happen on this edge.
  - DONE: done=1 for exactly one cycle. busy drops on the edge leaving DONE, returning to IDLE.
- Latency:
  - Normal request: done high in the cycle after edge N+2.
  - BAD_ADDR: done one cycle earlier.
  - start may be reasserted in the cycle immediately after done.
- Slots at index >= count are never compared, whatever their contents.
- Read port: rd_* registered from node[rd_address] each edge (1-cycle latency).
  - Read and write of the same node on the same edge returns the old contents.
  - rd_address >= BLOCKS returns all zeros.
- Arithmetic: count is 2 bits and never exceeds 3. next pointer values are stored verbatim, not range-checked.

Optional Feature:
BTREE_NODE_WRITER_DELETE_EN
- Defined: op=1 performs delete in PLACE.
  - Matching key at slot i: keys/data i+1..count-1 shift down one slot; next i+2..count shift down one slot. Vacated top slots are zeroed, count-1, status=0.
  - Key absent or count==0: no write, status=2.
- Undefined: op is ignored and every request is treated as insert/update.

Test Plan:
- Reset, then insert key 0x20/data 0x01/next 0 into node 3 -> done 3 cycles after start with status 0; rd node 3: count=1, key1=0x20, data1=0x01.
- Insert 0x40, then 0x10, into node 3 -> keys 0x10,0x20,0x40 in ascending order with data following; a 4th insert of 0x30 -> status 2, node unchanged.
- Insert 0x20/data 0x77 into the full node -> status 1; data2=0x77; count stays 3.
- Insert into address 20 with BLOCKS=16 -> done one cycle earlier with status 3; no node modified.
- Node 1 holds next0=5, key 0x50, next1=6; insert key 0x30 with next 9 -> next0=5, next1=9, next2=6; keys 0x30,0x50.
- Assert reset in PLACE cycle -> no write, busy=0, done never pulses; with DELETE_EN, delete 0x20 from {0x10,0x20,0x40} -> keys 0x10,0x40,0, count 2, status 0.
